// File: rtl/mem_request_arbiter.sv
//==============================================================================
// Module   : mem_request_arbiter
// Function : Latches instruction/data memory requests, drives a single-ported
//            RAM handshake and returns one-cycle ihit/dhit with registered data.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_request_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              halt,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              ihit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dhit,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready,
    output logic              err
);

    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DACC = 2'd1,
        S_IACC = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   store_q, store_d;
    logic                wr_q, wr_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic                ihit_q, ihit_d;
    logic                dhit_q, dhit_d;
    logic [DATA_W-1:0]   iload_q, iload_d;
    logic [DATA_W-1:0]   dload_q, dload_d;
    logic [c_cnt_w-1:0]  w_cnt_inc;

    assign w_cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        store_d = store_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;
        iload_d = iload_q;
        dload_d = dload_q;

        case (state_q)
            S_IDLE: begin
                // The cycle carrying a hit pulse is dead so the requester can
                // retire its request before it could be sampled twice.
                if (!(ihit_q || dhit_q)) begin
                    if (dREN || dWEN) begin
                        addr_d  = daddr;
                        store_d = dstore;
                        wr_d    = dWEN;
                        state_d = S_DACC;
                    end else if (iREN && !halt) begin
                        addr_d  = iaddr;
                        wr_d    = 1'b0;
                        state_d = S_IACC;
                    end
                end
            end
            S_DACC, S_IACC: begin
                if (ramready) begin
                    if (state_q == S_IACC) begin
                        iload_d = ramload;
                        ihit_d  = 1'b1;
                    end else begin
                        dhit_d = 1'b1;
                        if (!wr_q) begin
                            dload_d = ramload;
                        end
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_timeout) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Enables decode straight from state so an asynchronous reset drops them at once.
    assign ramREN   = (state_q == S_IACC) || ((state_q == S_DACC) && !wr_q);
    assign ramWEN   = (state_q == S_DACC) && wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign err      = (state_q == S_ERR);
    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign iload    = iload_q;
    assign dload    = dload_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
//==============================================================================
// Module   : tb_mem_request_arbiter
// Function : Self-checking bench for mem_request_arbiter with a RAM responder
//            and a hit scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_request_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          halt;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] iload;
    logic          ihit;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic [DW-1:0] dload;
    logic          dhit;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic          ramready;
    logic          err;

    mem_request_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .halt     (halt),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .ihit     (ihit),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dhit     (dhit),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramready (ramready),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RAM model: answers after ram_lat wait cycles unless stalled
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            ram_lat   = 0;
    bit            ram_stall = 1'b0;
    int            acc_cyc   = 0;

    initial begin
        ramready = 1'b0;
        ramload  = '0;
    end

    always @(posedge CLK) begin
        #1;
        ramready = 1'b0;
        ramload  = '0;
        if (ramREN || ramWEN) begin
            if (!ram_stall && acc_cyc >= ram_lat) begin
                ramready = 1'b1;
                if (ramWEN) begin
                    mem[ramaddr] = ramstore;
                end else begin
                    ramload = mem.exists(ramaddr) ? mem[ramaddr] : '0;
                end
                acc_cyc = 0;
            end else begin
                acc_cyc++;
            end
        end else begin
            acc_cyc = 0;
        end
    end

    typedef struct {
        logic          is_d;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] exp_dload = '0;

    always @(negedge CLK) begin
        if (!RST && (ihit || dhit)) begin
            if (sb.size() == 0) begin
                check("unexpected_hit", {62'd0, ihit, dhit}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("hit_overlap", {63'd0, ihit & dhit}, 64'd0);
                check("hit_kind", {63'd0, dhit}, {63'd0, mon_e.is_d});
                check("hit_load", mon_e.is_d ? dload : iload, mon_e.data);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic seen;

    initial begin
        RST = 1'b1; halt = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        mem[32'h40]  = 32'h3C01_0004;
        mem[32'h44]  = 32'h2400_0001;
        mem[32'h100] = 32'hDEAD_BEEF;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_hits", {62'd0, ihit, dhit}, 64'd0);
        check("rst_en_err", {61'd0, ramREN, ramWEN, err}, 64'd0);
        check("rst_loads", {iload, dload}, 64'd0);
        check("rst_ram", {ramaddr, ramstore}, 64'd0);
        step(); RST = 1'b0;
        repeat (2) step();

        // Single fetch, zero wait states
        step(); iREN = 1'b1; iaddr = 32'h40; sb.push_back('{1'b0, 32'h3C01_0004});
        step(); iREN = 1'b0; iaddr = '0;
        @(negedge CLK);
        check("fetch_ren", {62'd0, ramREN, ramWEN}, 64'd2);
        check("fetch_addr", ramaddr, 32'h40);
        @(negedge CLK);
        check("fetch_ihit", ihit, 1);
        @(negedge CLK);
        check("fetch_ihit_end", ihit, 0);
        repeat (2) step();

        // Data beats fetch when both are raised together
        step(); iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
        sb.push_back('{1'b1, 32'hDEAD_BEEF}); sb.push_back('{1'b0, 32'h2400_0001});
        exp_dload = 32'hDEAD_BEEF;
        step(); dREN = 1'b0; daddr = '0;
        @(negedge CLK);
        check("prio_daddr", ramaddr, 32'h100);
        check("prio_dren", ramREN, 1);
        @(negedge CLK);
        check("prio_dhit", dhit, 1);
        @(negedge CLK);
        check("prio_gap", {61'd0, ramREN, ihit, dhit}, 64'd0);
        step(); iREN = 1'b0; iaddr = '0;
        @(negedge CLK);
        check("prio_iacc", {ramREN, ramaddr}, {1'b1, 32'h44});
        @(negedge CLK);
        check("prio_ihit", ihit, 1);
        repeat (2) step();

        // Write with three wait states; inputs change after the request
        ram_lat = 3;
        step(); dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1234_5678;
        sb.push_back('{1'b1, exp_dload});
        step(); dWEN = 1'b0; dstore = '0; daddr = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("wr_enables", {62'd0, ramREN, ramWEN}, 64'd1);
            check("wr_store", ramstore, 32'h1234_5678);
        end
        @(negedge CLK);
        check("wr_dhit", dhit, 1);
        ram_lat = 0;
        check("wr_mem", mem[32'h200], 32'h1234_5678);
        repeat (2) step();

        // Halt blocks fetches only; read+write collapses to a write
        step(); halt = 1'b1; iREN = 1'b1; iaddr = 32'h40;
        seen = 1'b0;
        repeat (8) begin @(negedge CLK); seen |= ramREN | ramWEN; end
        check("halt_no_fetch", seen, 0);
        step(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hA5A5_5A5A;
        sb.push_back('{1'b1, exp_dload});
        step(); dREN = 1'b0; dWEN = 1'b0;
        @(negedge CLK);
        check("conf_enables", {62'd0, ramREN, ramWEN}, 64'd1);
        check("conf_addr", ramaddr, 32'h300);
        @(negedge CLK);
        check("conf_dhit", dhit, 1);
        seen = 1'b0;
        repeat (6) begin @(negedge CLK); seen |= ramREN | ramWEN; end
        check("halt_still_blocked", seen, 0);
        check("conf_mem", mem[32'h300], 32'hA5A5_5A5A);
        step(); halt = 1'b0; iREN = 1'b0;
        repeat (2) step();

        // Asynchronous reset in the middle of a data access
        ram_stall = 1'b1;
        step(); dREN = 1'b1; daddr = 32'h100;
        step(); dREN = 1'b0; daddr = '0;
        @(negedge CLK);
        check("mid_ren", ramREN, 1);
        #2 RST = 1'b1;
        #1;
        check("async_rst_en", {62'd0, ramREN, ramWEN}, 64'd0);
        check("async_rst_flags", {62'd0, dhit, err}, 64'd0);
        check("async_rst_addr", ramaddr, 32'h0);
        step(); step(); RST = 1'b0; ram_stall = 1'b0;
        exp_dload = '0;
        seen = 1'b0;
        repeat (5) begin @(negedge CLK); seen |= ramREN | ramWEN | dhit; end
        check("no_reissue", seen, 0);
        step(); iREN = 1'b1; iaddr = 32'h40; sb.push_back('{1'b0, 32'h3C01_0004});
        step(); iREN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("post_rst_ihit", ihit, 1);
        repeat (2) step();

        // Timeout: RAM never answers
        ram_stall = 1'b1;
        step(); dREN = 1'b1; daddr = 32'h100;
        step(); dREN = 1'b0; daddr = '0;
        for (int i = 0; i < TO; i++) begin
            @(negedge CLK);
            check("to_waiting", {62'd0, ramREN, err}, 64'd2);
        end
        @(negedge CLK);
        check("to_err", {61'd0, err, ramREN, ramWEN}, 64'd4);
        step(); dREN = 1'b1; iREN = 1'b1; iaddr = 32'h40;
        seen = 1'b0;
        repeat (6) begin @(negedge CLK); seen |= ramREN | ramWEN; end
        check("err_ignores_req", seen, 0);
        check("err_sticky", err, 1);
        step(); dREN = 1'b0; iREN = 1'b0; RST = 1'b1;
        @(negedge CLK);
        check("err_cleared", err, 0);
        step(); RST = 1'b0; ram_stall = 1'b0;
        repeat (2) step();

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
- Services the instruction-fetch and data requests raised by the decode/control path (iREN, dREN, dWEN) over a single-ported RAM.
- Latches each request, drives the RAM handshake, and returns a one-cycle ihit/dhit with registered load data.
- Data requests take priority over instruction fetch.
- Sits between the datapath and the RAM model; this is the responder end of the control unit's memory request interface.

Parameters:
- ADDR_W, 32, address width of every address port.
- DATA_W, 32, data width of every data port.
- TIMEOUT, 255, cycles an access may wait for ramready before the block enters ERR.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- halt  in  1  stop issuing new instruction fetches.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iload  out  DATA_W  fetched instruction; registered.
- ihit  out  1  one-cycle pulse: fetch complete, iload valid.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dload  out  DATA_W  read data; registered.
- dhit  out  1  one-cycle pulse: data access complete.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data; valid when ramready=1.
- ramready  in  1  RAM has completed the current access this cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, active-high RST):
  - state=IDLE; wait counter=0.
  - ihit, dhit, err, ramREN, ramWEN = 0.
  - iload, dload, ramaddr, ramstore = 0.
  - Takes effect immediately, including mid-access. The in-flight request is dropped and is not reissued after release.
- States: IDLE, DACC, IACC, ERR.
- IDLE:
  - If ihit or dhit is 1 this cycle (dead cycle), ignore all requests and stay in IDLE.
  - Else if dREN|dWEN: latch daddr, dstore and op into the request registers; go to DACC.
  - Else if iREN & !halt: latch iaddr; go to IACC.
  - Else stay in IDLE.
- Op selection: if dREN and dWEN are both 1, the access is a write and the read is dropped.
- DACC/IACC:
  - ramaddr and ramstore come from the latched registers; later input changes have no effect.
  - DACC drives ramREN or ramWEN per the latched op; IACC drives ramREN=1.
  - ramWEN is never 1 in IACC.
- Completion:
  - When ramready=1 at an edge: capture ramload into dload (read) or iload (IACC), pulse dhit or ihit for exactly the next cycle, clear the counter, return to IDLE.
  - A write leaves dload unchanged.
- Timeout:
  - The wait counter increments on each access cycle without ramready.
  - When it reaches TIMEOUT: go to ERR, deassert ram enables, set err=1.
  - ERR is left only by reset.
- Latency:
  - Request seen in IDLE at cycle N; RAM enables high in cycle N+1.
  - With ramready in cycle N+1, the hit pulse appears in cycle N+2.
  - The minimum gap between back-to-back hits is 3 cycles.
- Priority: if data and instruction requests are both pending in IDLE, data goes first. The fetch is serviced on the next eligible IDLE cycle.
- halt:
  - Blocks only new fetches. An in-flight IACC or DACC completes normally.
  - Data requests are still serviced under halt.
- Enables: ramREN and ramWEN are 0 in IDLE and ERR.

Test Plan:
- Reset: assert RST mid-DACC (ramREN=1) -> ramREN, dhit and err drop to 0 in the same cycle without waiting for an edge; state=IDLE after release.
- Read fetch: iREN=1, iaddr=0x0000_0040; ramready in cycle N+1 with ramload=0x3C01_0004 -> ihit=1 for exactly cycle N+2, iload=0x3C01_0004.
- Priority: iREN=1 and dREN=1 together, daddr=0x100, ramload=0xDEAD_BEEF -> data access first, dhit then dload=0xDEAD_BEEF. Then one dead cycle, then the IACC access, then ihit.
- Write/latching: dWEN=1, daddr=0x200, dstore=0x1234_5678; change dstore to 0 one cycle later; ramready after 3 wait cycles -> ramstore holds 0x1234_5678 throughout, ramWEN=1, dhit pulses once, dload unchanged.
- Halt/conflict: halt=1 with iREN=1 -> ramREN stays 0 indefinitely. Then dREN=dWEN=1 -> ramWEN=1, ramREN=0.
- Timeout: TIMEOUT=4, dREN=1, ramready held 0 -> err=1 after 4 wait cycles, enables 0; further requests ignored until RST.
